// File: rtl/sng_ramp_stream.sv
// Unary bitstream encoder: value v -> L-bit stream, bit k = (v > k*STRIDE); first bit one cycle after handshake.
// in_ready only in IDLE (no queuing); stall freezes the ramp and blanks that cycle's bit.
module sng_ramp_stream #(
    parameter int WIDTH  = 4,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic             stall,
    output logic             bit_out,
    output logic             bit_en,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH:0] STEP   = (WIDTH+1)'(STRIDE);
    localparam logic [WIDTH:0] LAST_R = (WIDTH+1)'((1 << WIDTH) - STRIDE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH:0]   r_q, r_d;
    logic             cmp_q, cmp_d;
    logic             fin_q, fin_d;
    logic             done_q, done_d;
    logic             emit;

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        r_d     = r_q;
        done_d  = 1'b0;
        emit    = (state_q == RUN) && !stall;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    v_d     = in_value;
                    r_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (fin_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        r_d     = '0;
                    end else begin
                        r_d = r_q + STEP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Comparator and end-of-period flag are precomputed for the ramp value of the next cycle.
        cmp_d = ({1'b0, v_d} > r_d);
        fin_d = (r_d == LAST_R);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            v_q     <= '0;
            r_q     <= '0;
            cmp_q   <= 1'b0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            r_q     <= r_d;
            cmp_q   <= cmp_d;
            fin_q   <= fin_d;
            done_q  <= done_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == RUN);
    assign bit_en   = emit;
    assign bit_out  = emit & cmp_q;
    assign last     = emit & fin_q;
    assign done     = done_q;

endmodule
